// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions the eight raw active-low mole buttons before the scoring stage.
//   Each button is synchronised (2 flops) and debounced with its own counter.
//   A small FSM then qualifies single-button presses and rejects mashing.
//   The result is a clean active-low vector with at most one bit low.
//   The downstream scorer treats any non-FF value as a hit attempt.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change
//   CNT_W            per-button counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous assert, active-low, synchronous release
//   btn_raw_n    in   8  raw buttons, asynchronous to clk, 0 = pressed
//   btn_n        out  8  qualified buttons, 0 = pressed, at most one bit low
//   multi_press  out  1  high while the FSM is in LOCKOUT
//   press_count  out  8  qualified presses since reset, saturating at 255
//
// Build option
//   ONE_SHOT_EN  when defined, btn_n pulses low for exactly one cycle per
//                counted press instead of holding for the whole press.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_raw_n,
  output logic [7:0] btn_n,
  output logic       multi_press,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser
  logic [7:0] sync1_q, sync2_q;

  // Debounce
  logic [7:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  // Qualification FSM and registered outputs
  state_e     state_q, state_d;
  logic [7:0] pressed_q, pressed_d;    // deb vector that was last counted
  logic [7:0] btn_n_q, btn_n_d;
  logic       multi_q, multi_d;
  logic [7:0] count_q, count_d;
  logic [3:0] npress;
  logic       count_inc;

  // NOTE: every signal written in an always_comb gets a default value first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        // Input agrees with the accepted level (or bounced back): restart.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    npress = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!deb_q[i]) npress = npress + 4'd1;
    end
  end

  // All deb bits that flipped this cycle are judged together through npress.
  always_comb begin
    state_d   = state_q;
    pressed_d = pressed_q;
    count_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (npress == 4'd1) begin
          state_d   = PRESSED;
          pressed_d = deb_q;
          count_inc = 1'b1;
        end else if (npress > 4'd1) begin
          state_d = LOCKOUT;
        end
      end
      PRESSED: begin
        if (deb_q == 8'hFF) begin
          state_d = IDLE;
        end else if (npress > 4'd1) begin
          state_d = LOCKOUT;
        end else if (deb_q != pressed_q) begin
          // Old button released and a new one accepted on the same cycle.
          pressed_d = deb_q;
          count_inc = 1'b1;
        end
      end
      LOCKOUT: begin
        // Only a full release re-arms; partial release keeps us locked out.
        if (deb_q == 8'hFF) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    if (count_inc && (count_q != 8'hFF)) count_d = count_q + 8'd1;

    multi_d = (state_d == LOCKOUT);

`ifdef ONE_SHOT_EN
    btn_n_d = count_inc ? deb_q : 8'hFF;
`else
    btn_n_d = (state_d == PRESSED) ? deb_q : 8'hFF;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 8'hFF;
      sync2_q   <= 8'hFF;
      deb_q     <= 8'hFF;
      // NOTE: the counter array is reset like any other flop; it is a bank of
      // registers, not a RAM, and a stale count would shorten the first debounce.
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      state_q   <= IDLE;
      pressed_q <= 8'hFF;
      btn_n_q   <= 8'hFF;
      multi_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= btn_raw_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      pressed_q <= pressed_d;
      btn_n_q   <= btn_n_d;
      multi_q   <= multi_d;
      count_q   <= count_d;
    end
  end

  assign btn_n       = btn_n_q;
  assign multi_press = multi_q;
  assign press_count = count_q;

endmodule
